// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - SPECIAL funct codes accepted by the unit
//   - FSM state encoding
//   - divide-by-zero result constants
//   - helper deciding whether a funct is a signed operation
package muldiv_pkg;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Divide by zero: LO is filled with this bit, HI returns the dividend.
    localparam logic DIV0_LO_BIT = 1'b1;

    function automatic logic is_signed_op(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue / result bundle between the execute stage and muldiv_unit.
//   w_start_1    issue request
//   w_op_code_6  SPECIAL funct code
//   w_flush_1    synchronous abort
//   w_rs_x       operand A (multiplicand / dividend / MTHI-MTLO data)
//   w_rt_x       operand B (multiplier / divisor)
//   w_busy_1     operation in flight
//   w_done_1     one-cycle pulse when HI/LO updated by MULT*/DIV*
//   w_hi_x       HI register
//   w_lo_x       LO register
// master = issuing side, slave = muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             w_start_1;
    logic [5:0]       w_op_code_6;
    logic             w_flush_1;
    logic [WIDTH-1:0] w_rs_x;
    logic [WIDTH-1:0] w_rt_x;
    logic             w_busy_1;
    logic             w_done_1;
    logic [WIDTH-1:0] w_hi_x;
    logic [WIDTH-1:0] w_lo_x;

    modport master (
        output w_start_1, w_op_code_6, w_flush_1, w_rs_x, w_rt_x,
        input  w_busy_1, w_done_1, w_hi_x, w_lo_x
    );

    modport slave (
        input  w_start_1, w_op_code_6, w_flush_1, w_rs_x, w_rt_x,
        output w_busy_1, w_done_1, w_hi_x, w_lo_x
    );
endinterface

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement.
//   in_val   value to pass through or negate
//   neg      1 = output -in_val, 0 = output in_val
//   out_val  result
// Used for operand magnitude and for final sign correction.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);
    assign out_val = neg ? (~in_val + W'(1)) : in_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//   w_clk    rising-edge clock
//   w_rst_n  asynchronous active-low reset
//   bus      muldiv_if slave: start/funct/flush/rs/rt in, busy/done/hi/lo out
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: MUL finishes as soon as the remaining
// multiplier bits are all zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO written here directly
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring iteration, one quotient bit per cycle
// FIX   | apply result signs, write HI/LO, pulse done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     w_clk,
    input logic     w_rst_n,
    muldiv_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q;          // multiplier (shifts right) / dividend->quotient (shifts left)
    logic [2*WIDTH-1:0]   b_q;          // multiplicand (shifts left) / divisor in low half
    logic [2*WIDTH-1:0]   acc_q;        // product / remainder in low half
    logic                 neg_lo_q;     // negate product or quotient
    logic                 neg_hi_q;     // negate remainder
    logic                 is_div_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q, busy_d, done_d;

    logic is_mul, is_div, sgn_op;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_src, rem_fix;

    assign is_mul = (bus.w_op_code_6 == FN_MULT) || (bus.w_op_code_6 == FN_MULTU);
    assign is_div = (bus.w_op_code_6 == FN_DIV)  || (bus.w_op_code_6 == FN_DIVU);
    assign sgn_op = is_signed_op(bus.w_op_code_6);

    muldiv_negate #(.W(WIDTH)) u_abs_rs (
        .in_val(bus.w_rs_x), .neg(sgn_op & bus.w_rs_x[WIDTH-1]), .out_val(rs_abs));
    muldiv_negate #(.W(WIDTH)) u_abs_rt (
        .in_val(bus.w_rt_x), .neg(sgn_op & bus.w_rt_x[WIDTH-1]), .out_val(rt_abs));

    // Partial remainder with the next dividend bit shifted in; a clear borrow
    // bit means the divisor fits and the quotient bit is 1.
    assign rem_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q[WIDTH-1:0]};

    // On divide by zero the untouched dividend magnitude becomes HI, and the
    // remainder sign correction restores the original rs value.
    assign rem_src = div_zero_q ? a_q : acc_q[WIDTH-1:0];

    muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
        .in_val(acc_q), .neg(neg_lo_q), .out_val(prod_fix));
    muldiv_negate #(.W(WIDTH)) u_fix_quo (
        .in_val(a_q), .neg(neg_lo_q), .out_val(quo_fix));
    muldiv_negate #(.W(WIDTH)) u_fix_rem (
        .in_val(rem_src), .neg(neg_hi_q), .out_val(rem_fix));

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.w_start_1 && is_mul)      state_d = ST_MUL;
                else if (bus.w_start_1 && is_div) state_d = ST_DIV;
            end
            ST_MUL: begin
`ifdef MULDIV_EARLY_OUT_EN
                if ((a_q == '0) || (cnt_q == CNT_LAST)) state_d = ST_FIX;
`else
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
`endif
            end
            ST_DIV: begin
                if (div_zero_q || (cnt_q == CNT_LAST)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.w_flush_1) state_d = ST_IDLE;
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIX) && !bus.w_flush_1;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.w_start_1 && !bus.w_flush_1) begin
                        if (bus.w_op_code_6 == FN_MTHI) hi_q <= bus.w_rs_x;
                        if (bus.w_op_code_6 == FN_MTLO) lo_q <= bus.w_rs_x;
                        if (is_mul || is_div) begin
                            a_q        <= is_mul ? rt_abs : rs_abs;
                            b_q        <= {{WIDTH{1'b0}}, (is_mul ? rs_abs : rt_abs)};
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            is_div_q   <= is_div;
                            div_zero_q <= is_div && (bus.w_rt_x == '0);
                            neg_lo_q   <= sgn_op & (bus.w_rs_x[WIDTH-1] ^ bus.w_rt_x[WIDTH-1]);
                            neg_hi_q   <= sgn_op & bus.w_rs_x[WIDTH-1];
                        end
                    end
                end
                ST_MUL: begin
                    if (a_q[0]) acc_q <= acc_q + b_q;
                    b_q   <= b_q << 1;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_DIV: begin
                    if (!div_zero_q) begin
                        if (!rem_diff[WIDTH]) begin
                            acc_q[WIDTH-1:0] <= rem_diff[WIDTH-1:0];
                            a_q              <= {a_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q[WIDTH-1:0] <= rem_shift[WIDTH-1:0];
                            a_q              <= {a_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.w_flush_1) begin
                        if (is_div_q) begin
                            lo_q <= div_zero_q ? {WIDTH{DIV0_LO_BIT}} : quo_fix;
                            hi_q <= rem_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.w_busy_1 = busy_q;
    assign bus.w_done_1 = done_q;
    assign bus.w_hi_x   = hi_q;
    assign bus.w_lo_x   = lo_q;

endmodule
